proc_array_ctrl: RTL

//  Sequencer for the input_buff -> proc_array correlation datapath. On start it drives
//  ena/cntin to load NDATA samples into input_buff, then waits for proc_array to settle.
//  It then registers doutA..doutD, selects the channel with the largest count, and

---
 rtl/proc_array_pkg.sv | 27 ++
 rtl/proc_array_max4.sv | 40 ++++
 rtl/proc_array_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/proc_array_pkg.sv
// -----------------------------------------------------------------------------
// proc_array_pkg
// Shared definitions for the input_buff -> proc_array correlation sequencer.
//   stateT          : sequencer state encoding (3 bits)
//   NDATA_DEF       : default samples per frame
//   NDATA_LOG_DEF   : default cntin width
//   CH_A..CH_D      : channel index codes reported on peak_ch
// -----------------------------------------------------------------------------
package proc_array_pkg;

    localparam int NDATA_DEF     = 128;
    localparam int NDATA_LOG_DEF = $clog2(NDATA_DEF);

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } stateT;

endpackage

// File: rtl/proc_array_max4.sv
// -----------------------------------------------------------------------------
// proc_array_max4
// Combinational 4-way unsigned maximum. Strict '>' compares in order a,b,c,d,
// so on a tie the lowest channel index is reported.
// Ports:
//   a,b,c,d  in   W   candidate values (channels A..D)
//   max      out  W   largest candidate
//   idx      out  2   winning channel (CH_A..CH_D)
// -----------------------------------------------------------------------------
module proc_array_max4
    import proc_array_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] max,
    output logic [1:0]   idx
);

    always_comb begin
        max = a;
        idx = CH_A;
        if (b > max) begin
            max = b;
            idx = CH_B;
        end
        if (c > max) begin
            max = c;
            idx = CH_C;
        end
        if (d > max) begin
            max = d;
            idx = CH_D;
        end
    end

endmodule

// File: rtl/proc_array_ctrl.sv
// -----------------------------------------------------------------------------
// proc_array_ctrl
// Frame sequencer: on start, drives ena/cntin to load NDATA samples into
// input_buff, waits SETTLE_CYC cycles for proc_array, captures doutA..D,
// picks the largest channel and pulses done.
// Optional feature macro: PROC_ARRAY_CTRL_THRESH_EN adds thresh input and
// detect output (detect = captured peak >= thresh).
// Ports:
//   clk            in   1            rising-edge clock
//   rst            in   1            asynchronous reset, active-low
//   start          in   1            frame request, sampled only in IDLE
//   abort          in   1            synchronous abort to IDLE, no done
//   doutA..doutD   in   NDATA_LOG+1  proc_array channel results
//   thresh         in   NDATA_LOG+1  detect threshold (macro only)
//   detect         out  1            peak >= thresh, valid with done (macro only)
//   ena            out  1            input_buff load enable
//   cntin          out  NDATA_LOG    input_buff write index
//   busy           out  1            high in every state except IDLE
//   done           out  1            one-cycle result-valid pulse
//   peak           out  NDATA_LOG+1  largest captured result
//   peak_ch        out  2            winning channel (0=A .. 3=D)
//   res_A..res_D   out  NDATA_LOG+1  captured copies of doutA..D
//   dbgState       out  3            current sequencer state
// Handshake: start is a level request honoured only in IDLE; it is neither
// queued nor acknowledged otherwise. done is a single-cycle pulse and the
// result outputs hold until the next capture.
// -----------------------------------------------------------------------------
module proc_array_ctrl
    import proc_array_pkg::*;
#(
    parameter int NDATA      = NDATA_DEF,
    parameter int NDATA_LOG  = $clog2(NDATA),
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NDATA_LOG:0]   doutA,
    input  logic [NDATA_LOG:0]   doutB,
    input  logic [NDATA_LOG:0]   doutC,
    input  logic [NDATA_LOG:0]   doutD,
`ifdef PROC_ARRAY_CTRL_THRESH_EN
    input  logic [NDATA_LOG:0]   thresh,
    output logic                 detect,
`endif
    output logic                 ena,
    output logic [NDATA_LOG-1:0] cntin,
    output logic                 busy,
    output logic                 done,
    output logic [NDATA_LOG:0]   peak,
    output logic [1:0]           peak_ch,
    output logic [NDATA_LOG:0]   res_A,
    output logic [NDATA_LOG:0]   res_B,
    output logic [NDATA_LOG:0]   res_C,
    output logic [NDATA_LOG:0]   res_D,
    output logic [2:0]           dbgState
);

    localparam int                   SETTLE_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [NDATA_LOG-1:0] LAST_IDX    = NDATA_LOG'(NDATA - 1);

    stateT               state;
    logic [SETTLE_W-1:0] settleCnt;
    logic [NDATA_LOG:0]  maxVal;
    logic [1:0]          maxIdx;

    assign dbgState = state;

    // Max is taken straight from the live dout inputs so peak and res_* are
    // registered on the same CAPTURE edge.
    proc_array_max4 #(.W(NDATA_LOG + 1)) uMax4 (
        .a   (doutA),
        .b   (doutB),
        .c   (doutC),
        .d   (doutD),
        .max (maxVal),
        .idx (maxIdx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            settleCnt <= '0;
            ena       <= 1'b0;
            cntin     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            peak      <= '0;
            peak_ch   <= CH_A;
            res_A     <= '0;
            res_B     <= '0;
            res_C     <= '0;
            res_D     <= '0;
`ifdef PROC_ARRAY_CTRL_THRESH_EN
            detect    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // abort outranks every transition; results are deliberately kept.
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                settleCnt <= '0;
                ena       <= 1'b0;
                cntin     <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= FILL;
                            ena   <= 1'b1;
                            cntin <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    FILL: begin
                        if (cntin == LAST_IDX) begin
                            cntin     <= '0;
                            ena       <= 1'b0;
                            settleCnt <= SETTLE_LOAD;
                            state     <= SETTLE;
                        end else begin
                            cntin <= cntin + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (settleCnt == '0) begin
                            state <= CAPTURE;
                        end else begin
                            settleCnt <= settleCnt - 1'b1;
                        end
                    end
                    CAPTURE: begin
                        res_A   <= doutA;
                        res_B   <= doutB;
                        res_C   <= doutC;
                        res_D   <= doutD;
                        peak    <= maxVal;
                        peak_ch <= maxIdx;
`ifdef PROC_ARRAY_CTRL_THRESH_EN
                        detect  <= (maxVal >= thresh);
`endif
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        ena   <= 1'b0;
                        cntin <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
